vjtag_bsc_host: RTL and testbench

//  JTAG host (initiator) driving the virtual boundary-scan cell chain from the other end of the TAP.

---
 rtl/vjtag_bsc_host_if.sv | 26 ++
 rtl/vjtag_bsc_host.sv | 170 +++++++++++++++++
 tb/tb_vjtag_bsc_host.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vjtag_bsc_host_if.sv
// Command/response channel of the JTAG scan host: one scan command in, captured DR vector out.
interface vjtag_bsc_host_if #(
    parameter int unsigned IR_W     = 1,
    parameter int unsigned DR_MAX   = 12,
    parameter int unsigned DR_LEN_W = 4
) ();
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_skip_ir;
    logic [IR_W-1:0]     cmd_ir;
    logic [DR_MAX-1:0]   cmd_dr;
    logic [DR_LEN_W-1:0] cmd_dr_len;
    logic                rsp_valid;
    logic [DR_MAX-1:0]   rsp_dr;
    logic                busy;

    modport master (
        output cmd_valid, cmd_skip_ir, cmd_ir, cmd_dr, cmd_dr_len,
        input  cmd_ready, rsp_valid, rsp_dr, busy
    );

    modport slave (
        input  cmd_valid, cmd_skip_ir, cmd_ir, cmd_dr, cmd_dr_len,
        output cmd_ready, rsp_valid, rsp_dr, busy
    );
endinterface

// File: rtl/vjtag_bsc_host.sv
// JTAG initiator: walks the TAP through an optional IR scan and a DR scan per command and
// returns the TDO bits captured while shifting the DR.
module vjtag_bsc_host #(
    parameter int unsigned IR_W     = 1,
    parameter int unsigned DR_MAX   = 12,
    parameter int unsigned DR_LEN_W = 4,
    parameter int unsigned TCK_DIV  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    vjtag_bsc_host_if.slave bus,
    output logic            jtag_tck,
    output logic            jtag_tms,
    output logic            jtag_tdi,
    input  logic            jtag_tdo
);
    localparam int unsigned StepN = (IR_W + 6 > DR_MAX + 5) ? IR_W + 6 : DR_MAX + 5;
    localparam int unsigned StepW = $clog2(StepN);
    localparam int unsigned DivW  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    typedef enum logic [2:0] {StInit, StIdle, StIr, StDr, StResp} state_e;

    state_e              state_q, state_d;
    logic [StepW-1:0]    step_q, step_d;
    logic [DivW-1:0]     div_q, div_d;
    logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [DR_MAX-1:0]   dr_q, dr_d, cap_q, cap_d, rsp_dr_q, rsp_dr_d;
    logic [DR_LEN_W-1:0] len_q, len_d, len_in;
    logic                tick;
    int unsigned         step, last;

    // TMS/TDI to present for TCK number s of the given scan state
    function automatic logic [1:0] tap_bits(state_e st, int unsigned s, logic [IR_W-1:0] ir,
                                            logic [DR_MAX-1:0] dr, int unsigned n);
        logic [IR_W-1:0]   irs;
        logic [DR_MAX-1:0] drs;
        logic              tms, tdi;
        irs = ir >> (s - 4);
        drs = dr >> (s - 3);
        tms = 1'b0;
        tdi = 1'b0;
        case (st)
            StInit: tms = (s < 5);
            StIr: begin
                if (s < 4) begin
                    tms = (s < 2);
                end else if (s < 4 + IR_W) begin
                    tms = (s == 3 + IR_W);
                    tdi = irs[0];
                end else begin
                    tms = (s == 4 + IR_W);
                end
            end
            StDr: begin
                if (s < 3) begin
                    tms = (s == 0);
                end else if (s < 3 + n) begin
                    tms = (s == 2 + n);
                    tdi = drs[0];
                end else begin
                    tms = (s == 3 + n);
                end
            end
            default: ;
        endcase
        return {tms, tdi};
    endfunction

    assign len_in = (bus.cmd_dr_len > DR_LEN_W'(DR_MAX)) ? DR_LEN_W'(DR_MAX) : bus.cmd_dr_len;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        div_d    = div_q;
        tck_d    = tck_q;
        tms_d    = tms_q;
        tdi_d    = tdi_q;
        ir_d     = ir_q;
        dr_d     = dr_q;
        len_d    = len_q;
        cap_d    = cap_q;
        rsp_dr_d = rsp_dr_q;
        step     = 32'(step_q);
        last     = (state_q == StInit) ? 5 : (state_q == StIr) ? IR_W + 5 : 32'(len_q) + 4;
        tick     = (state_q inside {StInit, StIr, StDr}) && (div_q == DivW'(TCK_DIV - 1));

        unique case (state_q)
            StIdle: begin
                tck_d = 1'b0;
                div_d = '0;
                if (bus.cmd_valid) begin
                    ir_d   = bus.cmd_ir;
                    dr_d   = bus.cmd_dr;
                    len_d  = len_in;
                    cap_d  = '0;
                    step_d = '0;
                    if (!bus.cmd_skip_ir)   state_d = StIr;
                    else if (len_in != '0)  state_d = StDr;
                    else                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: begin
                div_d = tick ? '0 : div_q + DivW'(1);
                if (tick) begin
                    tck_d = ~tck_q;
                    if (!tck_q) begin
                        if (state_q == StDr && step >= 3 && step < 3 + 32'(len_q)) begin
                            cap_d = cap_q | (DR_MAX'(jtag_tdo) << (step - 3));
                        end
                    end else if (step == last) begin
                        step_d = '0;
                        case (state_q)
                            StInit:  state_d = StIdle;
                            StIr:    state_d = (len_q != '0) ? StDr : StResp;
                            default: state_d = StResp;
                        endcase
                    end else begin
                        step_d = step_q + StepW'(1);
                    end
                end
            end
        endcase

        // New TCK slot begins: set up TMS/TDI while TCK is low
        if (state_d != state_q || step_d != step_q) begin
            {tms_d, tdi_d} = tap_bits(state_d, 32'(step_d), ir_d, dr_d, 32'(len_d));
        end
        if (state_d == StResp && state_q != StResp) begin
            rsp_dr_d = cap_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInit;
            step_q   <= '0;
            div_q    <= '0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            ir_q     <= '0;
            dr_q     <= '0;
            len_q    <= '0;
            cap_q    <= '0;
            rsp_dr_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            div_q    <= div_d;
            tck_q    <= tck_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
            ir_q     <= ir_d;
            dr_q     <= dr_d;
            len_q    <= len_d;
            cap_q    <= cap_d;
            rsp_dr_q <= rsp_dr_d;
        end
    end

    assign jtag_tck      = tck_q;
    assign jtag_tms      = tms_q;
    assign jtag_tdi      = tdi_q;
    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_dr    = rsp_dr_q;
endmodule

// File: tb/tb_vjtag_bsc_host.sv
// Bench for vjtag_bsc_host: a behavioural 1149.1 TAP target on the pins plus scan-rule expectations.
module tb_vjtag_bsc_host;
    localparam int unsigned IR_W     = 1;
    localparam int unsigned DR_MAX   = 12;
    localparam int unsigned DR_LEN_W = 4;
    localparam int unsigned TCK_DIV  = 4;

    typedef enum int {
        TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauDr, TapEx2Dr, TapUpDr,
        TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauIr, TapEx2Ir, TapUpIr
    } tap_e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic jtag_tck, jtag_tms, jtag_tdi;
    logic jtag_tdo = 1'b0;

    vjtag_bsc_host_if #(.IR_W(IR_W), .DR_MAX(DR_MAX), .DR_LEN_W(DR_LEN_W)) bus ();

    vjtag_bsc_host #(.IR_W(IR_W), .DR_MAX(DR_MAX), .DR_LEN_W(DR_LEN_W), .TCK_DIV(TCK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .jtag_tck (jtag_tck),
        .jtag_tms (jtag_tms),
        .jtag_tdi (jtag_tdi),
        .jtag_tdo (jtag_tdo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Target TAP model
    tap_e        tap = TapTlr;
    logic [31:0] pat = 0, pat_sh = 0, din = 0, iin = 0, dr_seen = 0, ir_seen = 0;
    int          dr_cnt = 0, ir_cnt = 0, dr_len_seen = 0, ir_len_seen = 0;
    int          dr_updates = 0, ir_updates = 0, tdi_bad = 0, tck_rises = 0;
    logic        tms_log[$];

    function automatic tap_e tap_next(tap_e s, logic tms);
        case (s)
            TapTlr:   return tms ? TapTlr   : TapRti;
            TapRti:   return tms ? TapSelDr : TapRti;
            TapSelDr: return tms ? TapSelIr : TapCapDr;
            TapCapDr: return tms ? TapEx1Dr : TapShDr;
            TapShDr:  return tms ? TapEx1Dr : TapShDr;
            TapEx1Dr: return tms ? TapUpDr  : TapPauDr;
            TapPauDr: return tms ? TapEx2Dr : TapPauDr;
            TapEx2Dr: return tms ? TapUpDr  : TapShDr;
            TapUpDr:  return tms ? TapSelDr : TapRti;
            TapSelIr: return tms ? TapTlr   : TapCapIr;
            TapCapIr: return tms ? TapEx1Ir : TapShIr;
            TapShIr:  return tms ? TapEx1Ir : TapShIr;
            TapEx1Ir: return tms ? TapUpIr  : TapPauIr;
            TapPauIr: return tms ? TapEx2Ir : TapPauIr;
            TapEx2Ir: return tms ? TapUpIr  : TapShIr;
            default:  return tms ? TapSelDr : TapRti;
        endcase
    endfunction

    always @(posedge jtag_tck) begin
        tap_e nxt;
        nxt = tap_next(tap, jtag_tms);
        tck_rises++;
        tms_log.push_back(jtag_tms);
        if (!(tap inside {TapShDr, TapShIr}) && jtag_tdi) tdi_bad++;
        case (tap)
            TapCapDr: begin dr_cnt = 0; din = 0; end
            TapCapIr: begin ir_cnt = 0; iin = 0; end
            TapShDr:  begin din = din | (32'(jtag_tdi) << dr_cnt); dr_cnt++; end
            TapShIr:  begin iin = iin | (32'(jtag_tdi) << ir_cnt); ir_cnt++; end
            default: ;
        endcase
        if (nxt == TapUpDr) begin dr_seen = din; dr_len_seen = dr_cnt; dr_updates++; end
        if (nxt == TapUpIr) begin ir_seen = iin; ir_len_seen = ir_cnt; ir_updates++; end
        tap = nxt;
    end

    always @(negedge jtag_tck) begin
        if (tap == TapShDr) begin
            pat_sh = pat >> dr_cnt;
            jtag_tdo = pat_sh[0];
        end
    end

    function automatic logic [31:0] pack(input logic q[$]);
        logic [31:0] v = 0;
        for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tck"}, 32'(jtag_tck), 0);
        check({tag, "_tms"}, 32'(jtag_tms), 1);
        check({tag, "_tdi"}, 32'(jtag_tdi), 0);
        check({tag, "_ready"}, 32'(bus.cmd_ready), 0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_dr"}, 32'(bus.rsp_dr), 0);
        check({tag, "_busy"}, 32'(bus.busy), 1);
    endtask

    // Release reset and expect exactly 5 TCK with TMS=1 then one with TMS=0
    task automatic release_and_check_init(input string tag);
        int cyc = 0;
        int rsp_cnt = 0;
        logic exp_q[$];
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tck_rises = 0;
        tms_log.delete();
        tdi_bad = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (!bus.cmd_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid) rsp_cnt++;
        end
        check({tag, "_ready"}, 32'(bus.cmd_ready), 1);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_tck_count"}, 32'(tck_rises), 6);
        check({tag, "_tms_seq"}, pack(tms_log), pack(exp_q));
        check({tag, "_tck_park"}, 32'(jtag_tck), 0);
        check({tag, "_tap_rti"}, 32'(tap == TapRti), 1);
        check({tag, "_no_rsp"}, 32'(rsp_cnt), 0);
        check({tag, "_tdi_idle"}, 32'(tdi_bad), 0);
    endtask

    task automatic run_cmd(input logic skip, input logic [IR_W-1:0] ir,
                           input logic [DR_MAX-1:0] dr, input logic [DR_LEN_W-1:0] len,
                           input logic [DR_MAX-1:0] tdo_pat);
        int unsigned n;
        int cyc, exp_cyc, ir_u0, dr_u0;
        logic [31:0] mask;
        logic exp_q[$];
        n = 32'(len);
        if (n > DR_MAX) n = DR_MAX;
        mask = 0;
        for (int i = 0; i < int'(n); i++) mask[i] = 1'b1;
        if (!skip) begin
            exp_q.push_back(1'b1); exp_q.push_back(1'b1);
            exp_q.push_back(1'b0); exp_q.push_back(1'b0);
            for (int i = 0; i < int'(IR_W); i++) exp_q.push_back(i == int'(IR_W) - 1);
            exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        end
        if (n > 0) begin
            exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
            for (int i = 0; i < int'(n); i++) exp_q.push_back(i == int'(n) - 1);
            exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        end
        exp_cyc = exp_q.size() * 2 * TCK_DIV;
        if (exp_cyc == 0) exp_cyc = 1;

        pat = 32'(tdo_pat);
        tck_rises = 0;
        tms_log.delete();
        tdi_bad = 0;
        ir_u0 = ir_updates;
        dr_u0 = dr_updates;

        @(negedge clk);
        bus.cmd_valid   = 1'b1;
        bus.cmd_skip_ir = skip;
        bus.cmd_ir      = ir;
        bus.cmd_dr      = dr;
        bus.cmd_dr_len  = len;
        cyc = 0;
        while (!bus.cmd_ready && cyc < 1000) begin @(negedge clk); cyc++; end
        check("accept_ready", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        // Keep a different command pending during the scan; it must not be taken
        bus.cmd_skip_ir = ~skip;
        bus.cmd_ir      = ~ir;
        bus.cmd_dr      = ~dr;
        bus.cmd_dr_len  = ~len;
        check("busy_after_accept", 32'(bus.busy), 1);
        check("ready_low_busy", 32'(bus.cmd_ready), 0);
        cyc = 1;
        while (!bus.rsp_valid && cyc < exp_cyc + 50) begin @(negedge clk); cyc++; end
        bus.cmd_valid = 1'b0;
        check("rsp_seen", 32'(bus.rsp_valid), 1);
        check("latency", (cyc >= exp_cyc - 1 && cyc <= exp_cyc + 1) ? 32'(exp_cyc) : 32'(cyc),
              32'(exp_cyc));
        check("rsp_dr", 32'(bus.rsp_dr), pat & mask);
        @(negedge clk);
        check("rsp_pulse", 32'(bus.rsp_valid), 0);
        check("rsp_hold", 32'(bus.rsp_dr), pat & mask);
        check("ready_again", 32'(bus.cmd_ready), 1);
        check("tck_park", 32'(jtag_tck), 0);
        check("tck_count", 32'(tck_rises), 32'(exp_q.size()));
        check("tms_seq", pack(tms_log), pack(exp_q));
        check("tap_rti", 32'(tap == TapRti), 1);
        check("tdi_idle", 32'(tdi_bad), 0);
        check("ir_updates", 32'(ir_updates - ir_u0), skip ? 0 : 1);
        check("dr_updates", 32'(dr_updates - dr_u0), (n > 0) ? 1 : 0);
        if (!skip) begin
            check("model_ir", ir_seen, 32'(ir));
            check("model_ir_len", 32'(ir_len_seen), IR_W);
        end
        if (n > 0) begin
            check("model_dr", dr_seen, 32'(dr) & mask);
            check("model_dr_len", 32'(dr_len_seen), n);
        end
    endtask

    initial begin
        int cyc;
        bus.cmd_valid   = 1'b0;
        bus.cmd_skip_ir = 1'b0;
        bus.cmd_ir      = '0;
        bus.cmd_dr      = '0;
        bus.cmd_dr_len  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        release_and_check_init("init");

        run_cmd(1'b0, 1'b1, 12'hA5C, 4'd12, 12'h3F0);
        run_cmd(1'b1, 1'b0, 12'h005, 4'd3, 12'h003);
        run_cmd(1'b1, 1'b1, 12'hFFF, 4'd0, 12'hABC);
        run_cmd(1'b0, 1'b0, 12'h123, 4'd15, 12'h9C6);
        run_cmd(1'b0, 1'b1, 12'h0F0, 4'd0, 12'h555);
        for (int k = 0; k < 25; k++) begin
            run_cmd(1'($urandom), IR_W'($urandom), DR_MAX'($urandom), DR_LEN_W'($urandom),
                    DR_MAX'($urandom));
        end

        // Abort a scan during DR bit 6
        pat = 32'hFFF;
        @(negedge clk);
        bus.cmd_valid   = 1'b1;
        bus.cmd_skip_ir = 1'b0;
        bus.cmd_ir      = 1'b1;
        bus.cmd_dr      = 12'h7E1;
        bus.cmd_dr_len  = 4'd12;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        cyc = 0;
        while (!(tap == TapShDr && dr_cnt == 6) && cyc < 2000) begin @(negedge clk); cyc++; end
        check("abort_reached_bit6", 32'(cyc < 2000), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (4) @(negedge clk);
        check("abort_no_rsp", 32'(bus.rsp_valid), 0);
        release_and_check_init("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
